image_write_arbiter: RTL and testbench
======================================

# image_write_arbiter

Frame-level controller that shares the single image writer sink between two pixel-producing filter pipelines. It grants whole frames round-robin and clears the sink before each frame. It streams two-pixel beats into the sink with the sink's hsync/pixel protocol, inserts optional inter-line gaps, and reports frame completion once the sink signals its file write is done. It sits between the filter pipelines and the image writer at the top of the image-processing testbench.

## Interface
- WIDTH, 768, image width in pixels; must be even
- HEIGHT, 512, image height in lines
- LINE_GAP, 0, idle cycles inserted after each line except the last (0 = none)
- DONE_TIMEOUT, 1024, cycles to wait for sink_done after the last beat before declaring an error
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- req0_frame, req1_frame  in  1  requester wants to send one frame; level-sensitive
- req0_valid, req1_valid  in  1  requester beat valid
- req0_data, req1_data  in  48  beat {R0,G0,B0,R1,G1,B1}, 8 bits each; pixel 0 is left of pixel 1
- req0_ready, req1_ready  out  1  beat accepted when valid && ready
- sink_hsync  out  1  beat strobe to the sink
- sink_pix  out  48  beat to the sink, same packing as req data
- sink_rstn  out  1  active-low clear pulse to the sink
- sink_done  in  1  sink write-complete level
- grant_id  out  1  requester currently granted
- busy  out  1  frame in progress (any state except IDLE)
- frame_done  out  1  one-cycle pulse at end of frame
- frame_err  out  1  valid with frame_done; 1 = sink_done timed out

## Operation
- FSM states: IDLE, CLR, LINE, GAP, WAIT, DONE.
- IDLE: when any reqN_frame = 1, grant and go to CLR.
  - If both request, grant the requester not granted last.
  - After reset, "last granted" = 1, so requester 0 wins the first tie.
- CLR: sink_rstn = 0 for exactly 1 cycle; col and row cleared; go to LINE.
- LINE: ready of the granted requester = 1; the other requester's ready = 0.
  - Each transfer increments col, range 0..WIDTH/2-1.
  - At col = WIDTH/2-1: col wraps to 0 and row increments.
  - At line end, go to GAP if LINE_GAP > 0 and this is not the last row; otherwise stay in LINE.
  - Transfer of the last beat (row = HEIGHT-1, col = WIDTH/2-1) goes to WAIT.
- GAP: ready = 0 for LINE_GAP cycles, then return to LINE.
- WAIT: ready = 0; timeout counter runs.
  - sink_done = 1 → DONE with err = 0.
  - Counter reaching DONE_TIMEOUT → DONE with err = 1.
- DONE: frame_done = 1 and frame_err = err for 1 cycle; "last granted" updated; go to IDLE.
- Counter widths: col = clog2(WIDTH/2), row = clog2(HEIGHT), timeout = clog2(DONE_TIMEOUT+1).
- Total beats per frame = WIDTH*HEIGHT/2 (196608 at defaults).

## Timing
- Reset values:
  - FSM = IDLE
  - sink_hsync = 0, sink_pix = 0, sink_rstn = 1
  - req0_ready = req1_ready = 0, grant_id = 0, busy = 0
  - frame_done = 0, frame_err = 0
  - last granted = 1
- Reset mid-frame aborts immediately: all outputs take reset values.
- sink_hsync and sink_pix are registered: a beat accepted at edge n appears at the sink from edge n to edge n+1; latency is 1 cycle.
- sink_hsync = 0 on any cycle without a transfer; sink_pix holds its last value.
- Readies are combinational from state and grant, with no dependency on valid.
- valid low mid-line: stall; counters hold; no beat lost or duplicated.
- reqN_frame is sampled only in IDLE.
  - Deassertion mid-frame does not abort the frame; the frame completes on beats only.
  - A requester holding req high gets a new frame after DONE if the other is idle.
- sink_done is ignored outside WAIT. A stale high level from the previous frame is removed by the CLR pulse, since the sink's done register resets.
- sink_done and timeout expiry in the same cycle: sink_done wins (err = 0).
- Minimum cycles per frame = 1 (IDLE→CLR) + 1 (CLR) + beats + (HEIGHT-1)*LINE_GAP + 1 (min WAIT) + 1 (DONE).

## Test plan
- Single frame, defaults (WIDTH=768, HEIGHT=512, LINE_GAP=0, DONE_TIMEOUT=1024), req0 always valid, sink_done asserted 2 cycles after the last beat:
  - exactly 196608 sink_hsync pulses, data in order
  - exactly one sink_rstn low cycle before the first beat
  - frame_done = 1, frame_err = 0
- Both frame requests high from reset, small image (8x4):
  - grant sequence 0,1,0,1
  - frame_done pulses in between
  - the non-granted ready is never 1
- Random valid deassertion (50%) on an 8x4 image with LINE_GAP = 3:
  - sink beat sequence equals the source sequence
  - 3-cycle hsync/ready gaps after lines 0–2 only
- sink_done held low → WAIT lasts DONE_TIMEOUT cycles; frame_done = 1 with frame_err = 1; returns to IDLE.
- HRESETn asserted mid-line (row 1, col 2):
  - all outputs take reset values immediately
  - after release with req1 only, the new frame starts with a CLR pulse and col = row = 0
- sink_done = 1 on the same edge the timeout expires → frame_err = 0.

Source files
------------

// File: rtl/image_write_arbiter_if.sv
// Signal bundle between the two filter pipelines, the image writer sink and the
// frame arbiter. The slave view belongs to the arbiter, the master view to its environment.
interface image_write_arbiter_if;
   logic        req0_frame;
   logic        req1_frame;
   logic        req0_valid;
   logic        req1_valid;
   logic [47:0] req0_data;
   logic [47:0] req1_data;
   logic        req0_ready;
   logic        req1_ready;
   logic        sink_hsync;
   logic [47:0] sink_pix;
   logic        sink_rstn;
   logic        sink_done;
   logic        grant_id;
   logic        busy;
   logic        frame_done;
   logic        frame_err;

   modport slave (
      input  req0_frame, req1_frame, req0_valid, req1_valid, req0_data, req1_data,
      input  sink_done,
      output req0_ready, req1_ready, sink_hsync, sink_pix, sink_rstn,
      output grant_id, busy, frame_done, frame_err
   );

   modport master (
      output req0_frame, req1_frame, req0_valid, req1_valid, req0_data, req1_data,
      output sink_done,
      input  req0_ready, req1_ready, sink_hsync, sink_pix, sink_rstn,
      input  grant_id, busy, frame_done, frame_err
   );
endinterface

// File: rtl/image_write_arbiter.sv
// Round-robin frame arbiter: grants whole frames from two pipelines to one image
// writer sink, clears the sink first, streams two-pixel beats and waits for write-done.
module image_write_arbiter #(
   parameter int WIDTH        = 768,
   parameter int HEIGHT       = 512,
   parameter int LINE_GAP     = 0,
   parameter int DONE_TIMEOUT = 1024
) (
   input logic                  HCLK,
   input logic                  HRESETn,
   image_write_arbiter_if.slave bus
);
   localparam int COL_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
   localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH / 2 - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
   localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(DONE_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_LINE = 3'd2,
      S_GAP  = 3'd3,
      S_WAIT = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t           state_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic [GAP_W-1:0] gap_q;
   logic [TMO_W-1:0] tmo_q;
   logic [TMO_W-1:0] tmo_d;
   logic             grant_q;
   logic             last_q;
   logic             hsync_q;
   logic [47:0]      pix_q;
   logic             rstn_q;
   logic             done_q;
   logic             err_q;
   logic             sel_valid_s;
   logic [47:0]      sel_data_s;
   logic             pick_d;
   logic             xfer_s;

   // Route the granted requester's beat and pick the winner of the next grant
   always_comb begin
      sel_valid_s = 1'b0;
      sel_data_s  = 48'd0;
      pick_d      = 1'b0;
      if (grant_q) begin
         sel_valid_s = bus.req1_valid;
         sel_data_s  = bus.req1_data;
      end else begin
         sel_valid_s = bus.req0_valid;
         sel_data_s  = bus.req0_data;
      end
      // On a tie the requester not served last wins
      if (bus.req0_frame && bus.req1_frame) begin
         pick_d = ~last_q;
      end else begin
         pick_d = bus.req1_frame;
      end
   end

   assign xfer_s = (state_q == S_LINE) && sel_valid_s;
   assign tmo_d  = tmo_q + TMO_W'(1);

   // Frame sequencing, beat counters and registered sink/status outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         hsync_q <= 1'b0;
         pix_q   <= 48'd0;
         rstn_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         hsync_q <= xfer_s;
         if (xfer_s) begin
            pix_q <= sel_data_s;
         end
         rstn_q <= 1'b1;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req0_frame || bus.req1_frame) begin
                  grant_q <= pick_d;
                  rstn_q  <= 1'b0;
                  state_q <= S_CLR;
               end
            end
            S_CLR: begin
               col_q   <= '0;
               row_q   <= '0;
               state_q <= S_LINE;
            end
            S_LINE: begin
               if (xfer_s) begin
                  if (col_q == LAST_COL) begin
                     col_q <= '0;
                     if (row_q == LAST_ROW) begin
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                     end else begin
                        row_q <= row_q + ROW_W'(1);
                        if (LINE_GAP > 0) begin
                           gap_q   <= '0;
                           state_q <= S_GAP;
                        end
                     end
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (gap_q == LAST_GAP) begin
                  state_q <= S_LINE;
               end else begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
            S_WAIT: begin
               // A done level arriving on the expiry edge still counts as success
               if (bus.sink_done) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (tmo_d == TMO_END) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            S_DONE: begin
               last_q  <= grant_q;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready = (state_q == S_LINE) && !grant_q;
   assign bus.req1_ready = (state_q == S_LINE) && grant_q;
   assign bus.sink_hsync = hsync_q;
   assign bus.sink_pix   = pix_q;
   assign bus.sink_rstn  = rstn_q;
   assign bus.grant_id   = grant_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.frame_done = done_q;
   assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_image_write_arbiter.sv
// Frame-level bench for image_write_arbiter on an 8x4 image with 3-cycle line gaps:
// a table of frame scenarios plus hand-written reset sequences, beats checked via a scoreboard.
module tb_image_write_arbiter;
   localparam int W     = 8;
   localparam int H     = 4;
   localparam int GAP   = 3;
   localparam int TMO   = 16;
   localparam int BEATS = W * H / 2;

   logic HCLK;
   logic HRESETn;
   image_write_arbiter_if bus ();

   image_write_arbiter #(
      .WIDTH(W), .HEIGHT(H), .LINE_GAP(GAP), .DONE_TIMEOUT(TMO)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic r0;    // req0_frame level
      logic r1;    // req1_frame level
      logic hold;  // keep the request high for the whole frame
      logic rnd;   // 50% random valid
      int   dly;   // cycles after the last sink beat before sink_done (-1 = never)
      int   lat;   // expected cycles from last sink beat to frame_done
      logic g;     // expected grant
      logic err;   // expected frame_err
   } vec_t;

   vec_t          tbl[8];
   int            total = 0;
   int            bad = 0;
   logic [47:0]   sb[$];
   int unsigned   cnt0 = 0;
   int unsigned   cnt1 = 0;
   logic          rnd = 1'b0;
   int            done_dly = -1;
   int            cyc_n = 0;
   int            beats, rstn_lows, runs_n, runs_bad, low_run;
   bit            seen_rdy;
   int            dn_cnt = 0;
   int            done_cyc = 0;
   int            last_beat_cyc = 0;
   logic          fe_at_done = 1'b0;

   function automatic logic [47:0] mk(input logic id, input int unsigned c);
      return {7'd0, id, 8'hA5, c};
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic clear_stats();
      beats     = 0;
      rstn_lows = 0;
      runs_n    = 0;
      runs_bad  = 0;
      low_run   = 0;
      seen_rdy  = 1'b0;
   endtask

   // Per-cycle observation after the edge: scoreboard, ready rules, sink model
   task automatic monitor();
      logic rg;
      logic ng;
      cyc_n++;
      ng = bus.grant_id ? bus.req0_ready : bus.req1_ready;
      check("nongrant_ready", ng, 1'b0);
      if (bus.sink_hsync) begin
         check("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) check("pix", bus.sink_pix, sb.pop_front());
         beats++;
         last_beat_cyc = cyc_n;
      end
      if (!bus.sink_rstn) begin
         rstn_lows++;
         check("rstn_before_beat", beats, 0);
         bus.sink_done = 1'b0;
      end
      rg = bus.grant_id ? bus.req1_ready : bus.req0_ready;
      if (rg) begin
         if (seen_rdy && low_run > 0) begin
            runs_n++;
            if (low_run != GAP) runs_bad++;
         end
         low_run  = 0;
         seen_rdy = 1'b1;
      end else if (seen_rdy) begin
         low_run++;
      end
      if (done_dly >= 0 && beats == BEATS && cyc_n - last_beat_cyc == done_dly)
         bus.sink_done = 1'b1;
      if (bus.frame_done) begin
         dn_cnt++;
         done_cyc   = cyc_n;
         fe_at_done = bus.frame_err;
      end
   endtask

   // One clock: drive beats, predict accepted ones, advance, observe
   task automatic cyc();
      logic v0, v1, p0, p1;
      v0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      bus.req0_data  = mk(1'b0, cnt0);
      bus.req1_data  = mk(1'b1, cnt1);
      #1;
      p0 = v0 && bus.req0_ready;
      p1 = v1 && bus.req1_ready;
      if (p0) sb.push_back(mk(1'b0, cnt0));
      if (p1) sb.push_back(mk(1'b1, cnt1));
      @(posedge HCLK);
      #1;
      if (p0) cnt0++;
      if (p1) cnt1++;
      monitor();
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      bit started;
      int dn0;
      clear_stats();
      bus.req0_frame = v.r0;
      bus.req1_frame = v.r1;
      rnd            = v.rnd;
      done_dly       = v.dly;
      started        = 1'b0;
      for (int i = 0; i < 10 && !started; i++) begin
         cyc();
         if (!bus.sink_rstn) started = 1'b1;
      end
      check({tag, ".start"}, started, 1'b1);
      check({tag, ".grant"}, bus.grant_id, v.g);
      check({tag, ".busy"}, bus.busy, 1'b1);
      if (!v.hold) begin
         bus.req0_frame = 1'b0;
         bus.req1_frame = 1'b0;
      end
      dn0 = dn_cnt;
      for (int i = 0; i < 400 && dn_cnt == dn0; i++) cyc();
      check({tag, ".done_seen"}, dn_cnt - dn0, 1);
      check({tag, ".beats"}, beats, BEATS);
      check({tag, ".rstn_lows"}, rstn_lows, 1);
      check({tag, ".gap_runs"}, runs_n, H - 1);
      check({tag, ".gap_len_bad"}, runs_bad, 0);
      check({tag, ".err"}, fe_at_done, v.err);
      check({tag, ".done_lat"}, done_cyc - last_beat_cyc, v.lat);
      check({tag, ".sb_left"}, sb.size(), 0);
      cyc();
      check({tag, ".done_pulse"}, {bus.frame_done, bus.busy}, 2'b00);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0,  2,  3, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1,  0,  1, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0,  5,  6, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, -1, 16, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 15, 16, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16, 16, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1,  3,  4, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0,  1,  2, 1'b1, 1'b0};

      HRESETn        = 1'b0;
      bus.req0_frame = 1'b0;
      bus.req1_frame = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = 48'd0;
      bus.req1_data  = 48'd0;
      bus.sink_done  = 1'b0;
      #12;
      check("reset.ctl", {bus.sink_hsync, bus.sink_rstn, bus.req0_ready, bus.req1_ready,
                          bus.grant_id, bus.busy, bus.frame_done, bus.frame_err}, 8'b0100_0000);
      check("reset.pix", bus.sink_pix, 48'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      for (int k = 0; k < 8; k++) begin
         run_frame(tbl[k], $sformatf("vec%0d", k));
      end

      // Reset in the middle of row 1, then a fresh frame from requester 1
      clear_stats();
      bus.req0_frame = 1'b1;
      bus.req1_frame = 1'b0;
      rnd            = 1'b0;
      done_dly       = -1;
      for (int i = 0; i < 60 && beats < W / 2 + 2; i++) cyc();
      check("midreset.reached", beats, W / 2 + 2);
      bus.req0_frame = 1'b0;
      #2;
      HRESETn = 1'b0;
      #1;
      check("midreset.ctl", {bus.sink_hsync, bus.sink_rstn, bus.req0_ready, bus.req1_ready,
                             bus.grant_id, bus.busy, bus.frame_done, bus.frame_err}, 8'b0100_0000);
      check("midreset.pix", bus.sink_pix, 48'd0);
      sb.delete();
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      run_frame('{1'b0, 1'b1, 1'b0, 1'b0, 4, 5, 1'b1, 1'b0}, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
